// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit bundle between the ID stage and the scoreboard: decoded ID-stage
// operands and pipeline controls in, stall/status out.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = $clog2(NUM_REGS),
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [6:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush_id;
  logic                  hold;
  logic                  stall;
  logic                  stall_load_use;
  logic                  stall_branch;
  logic [NUM_REGS-1:0]   busy_mask;
  logic [CNT_W-1:0]      stall_events;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_reg_write,
           id_mem_read, flush_id, hold,
    input  stall, stall_load_use, stall_branch, busy_mask, stall_events
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_reg_write,
           id_mem_read, flush_id, hold,
    output stall, stall_load_use, stall_branch, busy_mask, stall_events
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: each tracked register holds the number of
// cycles until its value is readable by the ID branch comparator.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = $clog2(NUM_REGS),
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave hz
);
  localparam int SB_W = $clog2(LOAD_LAT + 2);

  // Standard RV32I major opcodes.
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_S     = 7'b0100011;

  localparam logic [SB_W-1:0] LOAD_CNT = SB_W'(LOAD_LAT + 1);
  localparam logic [SB_W-1:0] ALU_CNT  = SB_W'(1);

  logic [SB_W-1:0]     cnt_view [NUM_REGS];
  logic [SB_W-1:0]     rs1_cnt;
  logic [SB_W-1:0]     rs2_cnt;
  logic                rs1_used;
  logic                rs2_used;
  logic                branch_use;
  logic                haz_rs1;
  logic                haz_rs2;
  logic                stall;
  logic                issue;
  logic [NUM_REGS-1:0] busy_vec;
  logic [CNT_W-1:0]    events_q;
  logic [CNT_W-1:0]    events_d;

  always_comb begin
    rs1_used   = !(hz.id_opcode == OP_LUI || hz.id_opcode == OP_AUIPC ||
                   hz.id_opcode == OP_JAL);
    rs2_used   = (hz.id_opcode == OP_R) || (hz.id_opcode == OP_B) ||
                 (hz.id_opcode == OP_S);
    branch_use = (hz.id_opcode == OP_B) || (hz.id_opcode == OP_JALR);
    rs1_cnt    = cnt_view[hz.id_rs1];
    rs2_cnt    = cnt_view[hz.id_rs2];
    // Non-branch consumers tolerate a count of 1: MEM/WB forwarding covers it.
    haz_rs1 = rs1_used && (hz.id_rs1 != '0) &&
              (branch_use ? (rs1_cnt != '0) : (rs1_cnt > ALU_CNT));
    haz_rs2 = rs2_used && (hz.id_rs2 != '0) &&
              (branch_use ? (rs2_cnt != '0) : (rs2_cnt > ALU_CNT));
    stall = hz.id_valid && !hz.flush_id && (haz_rs1 || haz_rs2);
    issue = hz.id_valid && !stall && !hz.flush_id && !hz.hold &&
            hz.id_reg_write && (hz.id_rd != '0);
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
    if (gi == 0) begin : g_zero
      assign cnt_view[gi] = '0;
    end else begin : g_track
      logic [SB_W-1:0] cnt_q;
      logic [SB_W-1:0] cnt_d;

      // A fresh issue overrides the decrement: the later writer is authoritative.
      always_comb begin
        cnt_d = cnt_q;
        if (issue && (hz.id_rd == REG_ADDR_W'(gi))) begin
          cnt_d = hz.id_mem_read ? LOAD_CNT : ALU_CNT;
        end else if (!hz.hold && (cnt_q != '0)) begin
          cnt_d = cnt_q - SB_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_view[gi] = cnt_q;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = (cnt_view[i] != '0);
    end
  end

  always_comb begin
    events_d = events_q;
    if (stall && !hz.hold && (events_q != '1)) begin
      events_d = events_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      events_q <= '0;
    end else begin
      events_q <= events_d;
    end
  end

  assign hz.stall          = stall;
  assign hz.stall_branch   = stall && branch_use;
  assign hz.stall_load_use = stall && !branch_use;
  assign hz.busy_mask      = busy_vec;
  assign hz.stall_events   = events_q;
endmodule
